dcache_wb_dm: RTL and testbench



---
 rtl/dcache_wb_dm.sv | 180 ++++++++++++++++++
 tb/tb_dcache_wb_dm.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_dm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dcache_wb_dm
// Purpose  : Direct-mapped, write-back, write-allocate data cache sitting
//            between a single-cycle core's D-mem port and a slow memory
//            that transfers one 4-word (128-bit) block at a time.
//            Hits complete in the request cycle with no added latency.
//            A miss stalls the core, writes back a dirty victim if there
//            is one, refills the line, then lets the held request hit.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_wb_dm #(
  parameter int NUM_BLOCKS = 8,
  parameter int ADDR_W     = 30,
  parameter int TAG_W      = ADDR_W - $clog2(NUM_BLOCKS) - 2
) (
  input  logic                clk,
  input  logic                rst_n,
  // core side
  input  logic                proc_read,
  input  logic                proc_write,
  input  logic [ADDR_W-1:0]   proc_addr,
  input  logic [31:0]         proc_wdata,
  output logic [31:0]         proc_rdata,
  output logic                proc_stall,
  // memory side
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [127:0]        mem_wdata,
  input  logic [127:0]        mem_rdata,
  input  logic                mem_ready
);

  // index width derived from the number of lines
  localparam int c_IW = $clog2(NUM_BLOCKS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  state_t                r_state;
  logic [127:0]          r_block [NUM_BLOCKS];
  logic [TAG_W-1:0]      r_tag   [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] r_valid;
  logic [NUM_BLOCKS-1:0] r_dirty;

  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [ADDR_W-3:0]     r_mem_addr;
  logic [127:0]          r_mem_wdata;

  // --------------------------------------------------------------------------
  // Address decode and hit detection
  // --------------------------------------------------------------------------
  logic [c_IW-1:0]       w_idx;
  logic [1:0]            w_off;
  logic [TAG_W-1:0]      w_tag;
  logic [6:0]            w_bitpos;
  logic                  w_req;
  logic                  w_hit;
  logic                  w_idle;
  logic [127:0]          w_line;
  logic [31:0]           w_word;
  logic                  w_victim_dirty;
  logic                  w_write_hit;

  assign w_idx    = proc_addr[c_IW+1:2];
  assign w_off    = proc_addr[1:0];
  assign w_tag    = proc_addr[ADDR_W-1:c_IW+2];
  // bit position of the addressed word inside the 128-bit line
  assign w_bitpos = {w_off, 5'd0};

  assign w_req    = proc_read | proc_write;
  assign w_hit    = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_idle   = (r_state == S_IDLE);
  assign w_line   = r_block[w_idx];
  assign w_word   = w_line[w_bitpos +: 32];

  // a victim needs writing back only if it holds modified data
  assign w_victim_dirty = r_valid[w_idx] & r_dirty[w_idx];

  // read+write together is resolved as a write
  assign w_write_hit = w_idle & proc_write & w_hit;

  // --------------------------------------------------------------------------
  // Core-facing outputs: combinational so a hit costs no extra cycle
  // --------------------------------------------------------------------------
  assign proc_stall = ~w_idle | (w_req & ~w_hit);
  assign proc_rdata = (w_idle & proc_read & ~proc_write & w_hit) ? w_word : 32'd0;

  // --------------------------------------------------------------------------
  // Memory-facing outputs come straight from registers so they stay
  // stable for the whole transfer regardless of core-side activity.
  // --------------------------------------------------------------------------
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Miss-handling FSM: tracks line state and drives the block transfers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // mem_ready is deliberately ignored here
          if (w_req && !w_hit) begin
            if (w_victim_dirty) begin
              r_state     <= S_WRITEBACK;
              r_mem_write <= 1'b1;
              r_mem_addr  <= {r_tag[w_idx], w_idx};
              r_mem_wdata <= r_block[w_idx];
            end else begin
              r_state     <= S_ALLOCATE;
              r_mem_read  <= 1'b1;
              r_mem_addr  <= {w_tag, w_idx};
            end
          end else if (w_write_hit) begin
            r_dirty[w_idx] <= 1'b1;
          end
        end

        S_WRITEBACK: begin
          // victim is now safe in memory; fetch the requested block next
          if (mem_ready) begin
            r_state     <= S_ALLOCATE;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
            r_mem_addr  <= {w_tag, w_idx};
          end
        end

        S_ALLOCATE: begin
          // fill lands at this edge; the held request hits next cycle
          if (mem_ready) begin
            r_state        <= S_IDLE;
            r_mem_read     <= 1'b0;
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Data/tag arrays: refill from memory or merge a store into a resident line
  always_ff @(posedge clk) begin
    // an abandoned fill must not land while reset is asserted
    if (rst_n) begin
      if (r_state == S_ALLOCATE && mem_ready) begin
        r_block[w_idx] <= mem_rdata;
        r_tag[w_idx]   <= w_tag;
      end else if (w_write_hit) begin
        r_block[w_idx][w_bitpos +: 32] <= proc_wdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_wb_dm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dcache_wb_dm
// Purpose  : Self-checking bench for dcache_wb_dm. A driver issues core
//            requests and pushes the expected responses (load data and
//            memory transfers) into queues; independent monitors pop and
//            compare when the DUT presents a completion or a transfer.
//            The reference is an architectural word memory plus a
//            per-line directory of which block each line holds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_wb_dm;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         proc_read = 1'b0;
  logic         proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  always #5 clk = ~clk;

  dcache_wb_dm #(.NUM_BLOCKS(8), .ADDR_W(30)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  int checks = 0;
  int fails  = 0;

  typedef struct {
    bit           is_write;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } mem_op_t;

  typedef struct {
    bit           is_read;
    logic [31:0]  rdata;
  } proc_op_t;

  mem_op_t  mem_q[$];
  proc_op_t proc_q[$];

  logic [127:0] mem_store [int];  // bench DRAM contents, keyed by block
  logic [31:0]  ref_mem   [int];  // architectural memory, keyed by word
  bit           m_valid [8];
  bit           m_dirty [8];
  int           m_blk   [8];

  bit auto_mem  = 1'b1;
  int lat_fixed = 0;

  // initial DRAM image: word k of block b holds b*16+k
  function automatic logic [31:0] init_word(int w);
    return 32'((w >> 2) * 16 + (w & 3));
  endfunction

  function automatic logic [127:0] dram_block(int b);
    logic [127:0] v;
    if (mem_store.exists(b)) return mem_store[b];
    for (int k = 0; k < 4; k++) v[k*32 +: 32] = init_word(b * 4 + k);
    return v;
  endfunction

  function automatic logic [31:0] ref_word(int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return init_word(w);
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_all();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  endtask

  task automatic abort(string name);
    checks++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    finish_all();
  endtask

  // Issue one core request, predicting its effect, and hold it until done
  task automatic do_req(bit wr, bit both, int addr, logic [31:0] wd);
    int      b;
    int      idx;
    int      n;
    mem_op_t op;
    logic [127:0] vb;
    b   = addr >> 2;
    idx = b % 8;
    if (!(m_valid[idx] && m_blk[idx] == b)) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int k = 0; k < 4; k++) vb[k*32 +: 32] = ref_word(m_blk[idx] * 4 + k);
        op.is_write = 1'b1;
        op.addr     = 28'(m_blk[idx]);
        op.wdata    = vb;
        mem_q.push_back(op);
      end
      op.is_write = 1'b0;
      op.addr     = 28'(b);
      op.wdata    = '0;
      mem_q.push_back(op);
      m_valid[idx] = 1'b1;
      m_blk[idx]   = b;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      ref_mem[addr] = wd;
      m_dirty[idx]  = 1'b1;
      proc_q.push_back('{is_read: 1'b0, rdata: 32'd0});
    end else begin
      proc_q.push_back('{is_read: 1'b1, rdata: ref_word(addr)});
    end

    @(posedge clk) #1;
    proc_write = wr;
    proc_read  = !wr || both;
    proc_addr  = 30'(addr);
    proc_wdata = wr ? wd : $urandom;
    n = 0;
    @(negedge clk);
    while (proc_stall) begin
      n++;
      if (n > 400) abort("req_done");
      @(negedge clk);
    end
    @(posedge clk) #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = 30'($urandom);
    repeat ($urandom_range(0, 1)) @(posedge clk);
  endtask

  // Core-side monitor: one completion per cycle with request high and no stall
  always @(negedge clk) begin
    proc_op_t e;
    if (rst_n && (proc_read || proc_write) && !proc_stall) begin
      if (proc_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL proc_unexpected: got completion expected none (t=%0t)", $time);
      end else begin
        e = proc_q.pop_front();
        if (e.is_read) check("proc_rdata", proc_rdata, e.rdata);
      end
    end
  end

  // Memory model: checks each transfer against the expectation and answers it
  initial begin
    forever begin
      @(negedge clk);
      if (auto_mem && rst_n && (mem_read || mem_write)) begin
        mem_op_t      e;
        bit           w;
        bit           stable;
        int           lat;
        logic [27:0]  a;
        logic [127:0] d;
        w = mem_write;
        a = mem_addr;
        d = mem_wdata;
        check("mem_exclusive", {mem_read, mem_write}, w ? 2'b01 : 2'b10);
        if (mem_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL mem_unexpected: got %s addr %h expected none (t=%0t)",
                   w ? "write" : "read", a, $time);
        end else begin
          e = mem_q.pop_front();
          check("mem_dir", w, e.is_write);
          check("mem_addr", a, e.addr);
          if (e.is_write) check("mem_wdata", d, e.wdata);
        end
        lat    = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 10);
        stable = 1'b1;
        repeat (lat - 1) begin
          @(negedge clk);
          if (mem_write !== w || mem_read !== !w || mem_addr !== a ||
              (w && mem_wdata !== d) || proc_stall !== 1'b1)
            stable = 1'b0;
        end
        check("mem_stable", stable, 1'b1);
        @(posedge clk) #1;
        mem_ready = 1'b1;
        if (!w) mem_rdata = dram_block(int'(a));
        @(posedge clk) #1;
        mem_ready = 1'b0;
        mem_rdata = {4{$urandom}};
        if (w) mem_store[int'(a)] = d;
        @(negedge clk);
        if (w) check("wb_to_alloc", {mem_write, mem_read, proc_stall}, 3'b011);
        else   check("fill_to_hit", {mem_read, mem_write, proc_stall}, 3'b000);
      end
    end
  end

  initial begin
    #5ms;
    checks++;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_all();
  end

  // Main stimulus
  initial begin
    int n;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_blk[i]   = 0;
    end

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_stall", proc_stall, 1'b0);
    check("rst_rdata", proc_rdata, 32'd0);
    check("rst_mem_req", {mem_read, mem_write}, 2'b00);
    check("rst_mem_addr", mem_addr, 28'd0);
    check("rst_mem_wdata", mem_wdata, 128'd0);

    // directed walk-through
    do_req(0, 0, 'h04, 0);
    do_req(0, 0, 'h05, 0);
    do_req(0, 0, 'h06, 0);
    do_req(0, 0, 'h07, 0);
    do_req(1, 0, 'h04, 32'hDEADBEEF);
    do_req(0, 0, 'h24, 0);
    do_req(1, 0, 'h40, 32'hCAFEF00D);
    do_req(0, 0, 'h40, 0);
    do_req(0, 0, 'h60, 0);
    do_req(0, 0, 'h04, 0);

    // latency sweep: dirty write-allocate then a conflicting read
    for (int l = 1; l <= 10; l++) begin
      lat_fixed = l;
      do_req(1, 0, ((16 + l) << 5) | ((l % 8) << 2) | (l % 4), $urandom);
      do_req(0, 0, ((40 + l) << 5) | ((l % 8) << 2) | ((l + 1) % 4), 0);
    end
    lat_fixed = 0;

    // reset during ALLOCATE, then a stray mem_ready
    auto_mem = 1'b0;
    @(posedge clk) #1;
    proc_read = 1'b1;
    proc_addr = 30'h1000;
    n = 0;
    @(negedge clk);
    while (!mem_read && !mem_write) begin
      n++;
      if (n > 20) abort("alloc_start");
      @(negedge clk);
    end
    check("abort_req", {mem_read, mem_write, proc_stall}, 3'b101);
    check("abort_addr", mem_addr, 28'h400);
    @(posedge clk) #1 rst_n = 1'b0;
    @(posedge clk) #1;
    rst_n     = 1'b1;
    proc_read = 1'b0;
    @(negedge clk);
    check("abort_dropped", {mem_read, mem_write, proc_stall}, 3'b000);
    @(posedge clk) #1;
    mem_ready = 1'b1;
    mem_rdata = {4{32'hBADBAD00}};
    @(posedge clk) #1;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("late_ready_ignored", {mem_read, mem_write, proc_stall}, 3'b000);
    // model the reset: cache empties, unsaved stores are lost
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    ref_mem.delete();
    foreach (mem_store[b])
      for (int k = 0; k < 4; k++) ref_mem[b * 4 + k] = mem_store[b][k*32 +: 32];
    auto_mem = 1'b1;
    do_req(0, 0, 'h1000, 0);
    do_req(0, 0, 'h04, 0);

    // randomized traffic over 8 tags x 8 lines
    for (int i = 0; i < 300; i++) begin
      bit wr;
      bit both;
      wr   = ($urandom_range(0, 2) == 0);
      both = wr && ($urandom_range(0, 9) == 0);
      do_req(wr, both, $urandom_range(0, 255), $urandom);
    end

    repeat (5) @(posedge clk);
    check("mem_q_empty", mem_q.size(), 0);
    check("proc_q_empty", proc_q.size(), 0);
    finish_all();
  end

endmodule
`default_nettype wire
